alu_arbiter: RTL and testbench

//  Shares one 8-bit alu instance between NREQ requesters using valid/ready

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu.sv | 32 +++
 rtl/rr_pick.sv | 34 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-alu arbiter slice.
//   ALU_W        datapath width of the shared alu
//   OP_*         3-bit alu function codes
//   state_t      arbiter FSM state encoding (ST_IDLE, ST_EXEC, ST_RESP)
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between the requesting control units
// and the shared alu arbiter.
//   req_valid/req_ready  per-requester handshake, req_ready one-hot
//   req_a/req_b/req_op   packed per-requester operands and opcode
//   rsp_valid/rsp_ready  result handshake
//   rsp_data/rsp_id      alu result and owning requester index
//   busy/op_count        arbiter status
// modport slave is the arbiter side, master the requester/consumer side.
interface alu_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic [CNTW-1:0]   op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
    );
endinterface

// File: rtl/alu.sv
// alu: shared 8-bit combinational alu.
//   a, b   operands
//   f      function code (OP_* in alu_pkg)
//   q      result, modulo 2^ALU_W
//   cout   carry for add, borrow for sub, shifted-out bit for shifts
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       f,
    output logic [ALU_W-1:0] q,
    output logic             cout
);

    always_comb begin
        q    = '0;
        cout = 1'b0;
        case (f)
            OP_ADD:  {cout, q} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {cout, q} = {1'b0, a} - {1'b0, b};
            OP_OR:   q = a | b;
            OP_AND:  q = a & b;
            OP_XOR:  q = a ^ b;
            OP_NOT:  q = ~a;
            OP_SHL:  {cout, q} = {a, 1'b0};
            OP_SHR:  {q, cout} = {1'b0, a};
            default: q = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req      request vector
//   ptr      highest-priority index; search runs ptr, ptr+1, ... mod NREQ
//   gnt      one-hot grant, all zero when no request
//   gnt_idx  index of the granted request, 0 when no request
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found;
    logic [IDW-1:0] j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between NREQ requesters with round-robin
// arbitration. A granted request is captured, executed for one cycle and
// returned tagged with the requester id.
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset; aborts any operation in flight
//   bus     alu_arbiter_if slave port (request, response and status)
//
// state   | meaning
// ST_IDLE | accepting; grant the next valid requester from rr_ptr
// ST_EXEC | alu runs on the captured operands, result registered
// ST_RESP | rsp_valid high, waiting for rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    state_t            state_q,     state_d;
    logic [IDW-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [ALU_W-1:0]  a_q,         a_d;
    logic [ALU_W-1:0]  b_q,         b_d;
    logic [2:0]        op_q,        op_d;
    logic [IDW-1:0]    id_q,        id_d;
    logic [ALU_W-1:0]  rsp_data_q,  rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CNTW-1:0]   op_count_q,  op_count_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic [ALU_W-1:0]  alu_q;
    logic              unused_cout;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    alu u_alu (
        .a    (a_q),
        .b    (b_q),
        .f    (op_q),
        .q    (alu_q),
        .cout (unused_cout)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    a_d      = bus.req_a[int'(gnt_idx)*ALU_W +: ALU_W];
                    b_d      = bus.req_b[int'(gnt_idx)*ALU_W +: ALU_W];
                    op_d     = bus.req_op[int'(gnt_idx)*3 +: 3];
                    id_d     = gnt_idx;
                    rr_ptr_d = IDW'((int'(gnt_idx) + 1) % NREQ);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    // Grant is only visible in IDLE and never while reset is asserted.
    assign bus.req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        bus.req_a[8*id +: 8]  = a;
        bus.req_b[8*id +: 8]  = b;
        bus.req_op[3*id +: 3] = op;
        bus.req_valid[id]     = 1'b1;
    endtask

    // Bounded wait for any grant, then check it is the expected requester.
    task automatic wait_grant(input int id);
        logic [NREQ-1:0] exp_g;
        exp_g = '0;
        exp_g[id] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (bus.req_ready != '0) break;
            @(negedge clk);
        end
        chk_val("grant", bus.req_ready, exp_g);
        chk_val("idle_at_grant", bus.busy, 1'b0);
    endtask

    // Single request with rsp_ready held high; checks the N, N+1, N+2 timing.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] exp_q);
        @(negedge clk);
        set_req(id, a, b, op);
        wait_grant(id);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        chk_val("exec_no_rsp", bus.rsp_valid, 1'b0);
        chk_val("exec_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk_val("rsp_valid", bus.rsp_valid, 1'b1);
        chk_val("rsp_data", bus.rsp_data, exp_q);
        chk_val("rsp_id", bus.rsp_id, id);
        @(negedge clk);
        exp_cnt++;
        chk_val("rsp_done", bus.rsp_valid, 1'b0);
        chk_val("op_count", bus.op_count, exp_cnt[CNTW-1:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1 chk_val("ready_in_reset", bus.req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk_val("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk_val("rst_rsp_data", bus.rsp_data, 0);
        chk_val("rst_rsp_id", bus.rsp_id, 0);
        chk_val("rst_op_count", bus.op_count, 0);
        chk_val("rst_busy", bus.busy, 1'b0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp3 [4];
        logic [15:0] cnt_hold;
        exp3[0] = 8'h12; exp3[1] = 8'h23; exp3[2] = 8'h34; exp3[3] = 8'h45;

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
        do_reset();

        // basic operations and opcode coverage
        do_op(0, 8'hF0, 8'h20, OP_ADD, 8'h10);
        do_op(2, 8'h05, 8'h07, OP_SUB, 8'hFE);
        do_op(1, 8'h81, 8'h00, OP_SHL, 8'h02);
        do_op(3, 8'h81, 8'h00, OP_SHR, 8'h40);
        do_op(0, 8'h3C, 8'h00, OP_NOT, 8'hC3);
        do_op(1, 8'h50, 8'h0A, OP_OR,  8'h5A);
        do_op(2, 8'hF0, 8'h3C, OP_AND, 8'h30);

        // all four held valid from reset: grants 0,1,2,3,0
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h11 * (i + 1)), 8'h01, OP_ADD);
        for (int g = 0; g < 5; g++) begin
            wait_grant(g % NREQ);
            @(negedge clk);
            chk_val("rr_busy_no_grant", bus.req_ready, 0);
            @(negedge clk);
            chk_val("rr_resp_no_grant", bus.req_ready, 0);
            chk_val("rr_rsp_id", bus.rsp_id, g % NREQ);
            chk_val("rr_rsp_data", bus.rsp_data, exp3[g % NREQ]);
            @(negedge clk);
            if (g == 4) bus.req_valid = '0;
            exp_cnt++;
            chk_val("rr_op_count", bus.op_count, exp_cnt[CNTW-1:0]);
        end

        // consumer stalls for 5 cycles in RESP
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 8'hAA, 8'h0F, OP_XOR);
        wait_grant(0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        set_req(3, 8'h01, 8'h01, OP_ADD);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk_val("stall_valid", bus.rsp_valid, 1'b1);
            chk_val("stall_data", bus.rsp_data, 8'hA5);
            chk_val("stall_id", bus.rsp_id, 0);
            chk_val("stall_no_grant", bus.req_ready, 0);
            chk_val("stall_count", bus.op_count, exp_cnt[CNTW-1:0]);
            @(negedge clk);
        end
        bus.rsp_ready    = 1'b1;
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        exp_cnt++;
        chk_val("stall_done", bus.rsp_valid, 1'b0);
        chk_val("stall_count_after", bus.op_count, exp_cnt[CNTW-1:0]);

        // reset during EXEC aborts the operation and clears rr_ptr
        @(negedge clk);
        set_req(2, 8'h09, 8'h01, OP_SUB);
        wait_grant(2);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        chk_val("abort_busy", bus.busy, 1'b0);
        chk_val("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk_val("abort_op_count", bus.op_count, 0);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk_val("abort_no_rsp", bus.rsp_valid, 1'b0);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h10, 8'h01, OP_ADD);
        wait_grant(0);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk_val("abort_next_data", bus.rsp_data, 8'h11);
        @(negedge clk);
        exp_cnt++;
        chk_val("abort_next_count", bus.op_count, exp_cnt[CNTW-1:0]);

        // op_count wrap from FFFF to 0
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        cnt_hold = bus.op_count;
        chk_val("preload", cnt_hold, 16'hFFFF);
        exp_cnt = 32'hFFFF;
        do_op(1, 8'h01, 8'h02, OP_ADD, 8'h03);
        chk_val("wrap_zero", bus.op_count, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
